// File: rtl/halloween_pkg.sv
// Shared opcode map, drive codes and FSM state types for the decoration effect blocks.
package halloween_pkg;

  localparam int unsigned CMD_W = 16;

  localparam int unsigned OP_ON     = 0;
  localparam int unsigned OP_RESET  = 1;
  localparam int unsigned OP_GREEN  = 4;
  localparam int unsigned OP_PURPLE = 5;
  localparam int unsigned OP_ORANGE = 6;
  localparam int unsigned OP_SCREAM = 8;
  localparam int unsigned OP_CACKLE = 9;
  localparam int unsigned OP_BOO    = 10;
  localparam int unsigned OP_WAVE   = 12;
  localparam int unsigned OP_JAW    = 13;
  localparam int unsigned OP_FOG    = 14;

  // Opcodes 2, 3, 7, 11 and 15 are unassigned and treated as malformed.
  localparam logic [CMD_W-1:0] OP_RSVD_MASK = 16'h888C;

  localparam logic [1:0] COLOR_OFF    = 2'b00;
  localparam logic [1:0] COLOR_GREEN  = 2'b01;
  localparam logic [1:0] COLOR_PURPLE = 2'b10;
  localparam logic [1:0] COLOR_ORANGE = 2'b11;

  localparam logic [1:0] SND_SCREAM = 2'b00;
  localparam logic [1:0] SND_CACKLE = 2'b01;
  localparam logic [1:0] SND_BOO    = 2'b10;

  typedef enum logic {SND_IDLE, SND_PLAY} snd_state_t;
  typedef enum logic [1:0] {FOG_IDLE, FOG_ON, FOG_COOL} fog_state_t;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/effect_timer.sv
// Down-counting activity timer: active for exactly LEN cycles after a load; a load while
// active restarts the full LEN; clr cancels synchronously.
module effect_timer #(
  parameter int unsigned LEN = 4,
  parameter int unsigned W   = $clog2(LEN) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_load,
  output logic o_active,
  output logic o_last
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                r_cnt <= '0;
    else if (i_clr)         r_cnt <= '0;
    else if (i_load)        r_cnt <= W'(LEN);
    else if (r_cnt != '0)   r_cnt <= r_cnt - W'(1);
  end

  assign o_active = (r_cnt != '0);
  assign o_last   = (r_cnt == W'(1));

endmodule

// File: rtl/effect_actuator.sv
// Turns decoded one-hot sequencer commands into lamp, sound, movement and fog drive,
// with power/soft-reset handling and a saturating malformed-command counter.
module effect_actuator
  import halloween_pkg::*;
#(
  parameter int unsigned SOUND_LEN = 8,
  parameter int unsigned MOVE_LEN  = 4,
  parameter int unsigned FOG_LEN   = 6,
  parameter int unsigned COOL_LEN  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_cmd_valid,
  input  logic [CMD_W-1:0] i_cmd_onehot,
  output logic             o_powered,
  output logic [1:0]       o_color,
  output logic             o_snd_active,
  output logic [1:0]       o_snd_sel,
  output logic             o_hands_active,
  output logic             o_jaw_active,
  output logic             o_fog_active,
  output logic             o_fog_cooldown,
  output logic             o_busy_drop,
  output logic [7:0]       o_err_count
);

  localparam int unsigned TMR_W =
    $clog2(max2(max2(SOUND_LEN, MOVE_LEN), max2(FOG_LEN, COOL_LEN))) + 1;

  snd_state_t r_snd_state, w_snd_state_nxt;
  fog_state_t r_fog_state, w_fog_state_nxt;

  logic w_well, w_malformed, w_act, w_on_acc, w_soft;
  logic w_color_cmd, w_snd_cmd, w_snd_acc, w_fog_cmd, w_fog_acc, w_busy;
  logic w_snd_last, w_fog_last, w_cool_load;
  logic w_unused_hands_last, w_unused_jaw_last, w_unused_cool_last;
  logic [1:0] w_color, w_sel;

  // Command classification; anything but a single assigned opcode is malformed.
  assign w_well      = i_cmd_valid && $onehot(i_cmd_onehot) &&
                       ((i_cmd_onehot & OP_RSVD_MASK) == '0);
  assign w_malformed = i_cmd_valid && !w_well;
  assign w_act       = w_well && o_powered;
  assign w_on_acc    = w_well && !o_powered && i_cmd_onehot[OP_ON];
  assign w_soft      = w_act && i_cmd_onehot[OP_RESET];

  assign w_color_cmd = w_act && (i_cmd_onehot[OP_GREEN] || i_cmd_onehot[OP_PURPLE] ||
                                 i_cmd_onehot[OP_ORANGE]);
  assign w_color     = i_cmd_onehot[OP_ORANGE] ? COLOR_ORANGE :
                       i_cmd_onehot[OP_PURPLE] ? COLOR_PURPLE : COLOR_GREEN;

  assign w_snd_cmd = w_act && (i_cmd_onehot[OP_SCREAM] || i_cmd_onehot[OP_CACKLE] ||
                               i_cmd_onehot[OP_BOO]);
  assign w_snd_acc = w_snd_cmd && (r_snd_state == SND_IDLE);
  assign w_sel     = i_cmd_onehot[OP_BOO]    ? SND_BOO :
                     i_cmd_onehot[OP_CACKLE] ? SND_CACKLE : SND_SCREAM;

  assign w_fog_cmd   = w_act && i_cmd_onehot[OP_FOG];
  assign w_fog_acc   = w_fog_cmd && (r_fog_state == FOG_IDLE);
  assign w_cool_load = (r_fog_state == FOG_ON) && w_fog_last;

  assign w_busy = (w_snd_cmd && (r_snd_state != SND_IDLE)) ||
                  (w_fog_cmd && (r_fog_state != FOG_IDLE));

  effect_timer #(.LEN(SOUND_LEN), .W(TMR_W)) u_snd_tmr (
    .clk(clk), .rst(rst), .i_clr(w_soft), .i_load(w_snd_acc),
    .o_active(o_snd_active), .o_last(w_snd_last));

  effect_timer #(.LEN(MOVE_LEN), .W(TMR_W)) u_hands_tmr (
    .clk(clk), .rst(rst), .i_clr(w_soft), .i_load(w_act && i_cmd_onehot[OP_WAVE]),
    .o_active(o_hands_active), .o_last(w_unused_hands_last));

  effect_timer #(.LEN(MOVE_LEN), .W(TMR_W)) u_jaw_tmr (
    .clk(clk), .rst(rst), .i_clr(w_soft), .i_load(w_act && i_cmd_onehot[OP_JAW]),
    .o_active(o_jaw_active), .o_last(w_unused_jaw_last));

  effect_timer #(.LEN(FOG_LEN), .W(TMR_W)) u_fog_tmr (
    .clk(clk), .rst(rst), .i_clr(w_soft), .i_load(w_fog_acc),
    .o_active(o_fog_active), .o_last(w_fog_last));

  // Cooldown starts on the edge fog drive ends, so the two never overlap or leave a gap.
  effect_timer #(.LEN(COOL_LEN), .W(TMR_W)) u_cool_tmr (
    .clk(clk), .rst(rst), .i_clr(w_soft), .i_load(w_cool_load),
    .o_active(o_fog_cooldown), .o_last(w_unused_cool_last));

  always_comb begin
    w_snd_state_nxt = r_snd_state;
    w_fog_state_nxt = r_fog_state;
    case (r_snd_state)
      SND_IDLE: if (w_snd_acc)  w_snd_state_nxt = SND_PLAY;
      SND_PLAY: if (w_snd_last) w_snd_state_nxt = SND_IDLE;
    endcase
    case (r_fog_state)
      FOG_IDLE: if (w_fog_acc)  w_fog_state_nxt = FOG_ON;
      FOG_ON:   if (w_fog_last) w_fog_state_nxt = FOG_COOL;
      FOG_COOL: if (!o_fog_cooldown || w_unused_cool_last) w_fog_state_nxt = FOG_IDLE;
      default:  w_fog_state_nxt = FOG_IDLE;
    endcase
    if (w_soft) begin
      w_snd_state_nxt = SND_IDLE;
      w_fog_state_nxt = FOG_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_snd_state <= SND_IDLE;
      r_fog_state <= FOG_IDLE;
      o_powered   <= 1'b0;
      o_color     <= COLOR_OFF;
      o_snd_sel   <= SND_SCREAM;
      o_busy_drop <= 1'b0;
      o_err_count <= 8'd0;
    end else begin
      r_snd_state <= w_snd_state_nxt;
      r_fog_state <= w_fog_state_nxt;
      o_busy_drop <= w_busy;
      if (w_malformed && (o_err_count != 8'hFF)) o_err_count <= o_err_count + 8'd1;
      if (w_soft) begin
        o_powered <= 1'b0;
        o_color   <= COLOR_OFF;
        o_snd_sel <= SND_SCREAM;
      end else begin
        if (w_on_acc)    o_powered <= 1'b1;
        if (w_color_cmd) o_color   <= w_color;
        if (w_snd_acc)   o_snd_sel <= w_sel;
      end
    end
  end

endmodule

// File: tb/tb_effect_actuator.sv
// Scoreboard bench for effect_actuator: directed commands push expected outputs, a
// monitor compares them one cycle later.
module tb_effect_actuator;

  localparam int SL = 8;
  localparam int ML = 4;
  localparam int FL = 6;
  localparam int CL = 10;

  logic clk = 1'b0;
  logic rst;
  logic i_cmd_valid;
  logic [15:0] i_cmd_onehot;
  logic o_powered, o_snd_active, o_hands_active, o_jaw_active;
  logic o_fog_active, o_fog_cooldown, o_busy_drop;
  logic [1:0] o_color, o_snd_sel;
  logic [7:0] o_err_count;

  always #5 clk = ~clk;

  effect_actuator #(.SOUND_LEN(SL), .MOVE_LEN(ML), .FOG_LEN(FL), .COOL_LEN(CL)) dut (
    .clk(clk), .rst(rst), .i_cmd_valid(i_cmd_valid), .i_cmd_onehot(i_cmd_onehot),
    .o_powered(o_powered), .o_color(o_color), .o_snd_active(o_snd_active),
    .o_snd_sel(o_snd_sel), .o_hands_active(o_hands_active), .o_jaw_active(o_jaw_active),
    .o_fog_active(o_fog_active), .o_fog_cooldown(o_fog_cooldown),
    .o_busy_drop(o_busy_drop), .o_err_count(o_err_count));

  // {powered, color, snd_active, snd_sel, hands, jaw, fog, cooldown, busy_drop, err_count}
  logic [18:0] act;
  assign act = {o_powered, o_color, o_snd_active, o_snd_sel, o_hands_active, o_jaw_active,
                o_fog_active, o_fog_cooldown, o_busy_drop, o_err_count};

  logic [18:0] q_exp[$];
  string       q_tag[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: effect windows are kept as absolute end cycles.
  int k = 0;
  bit m_pw, m_busy;
  logic [1:0] m_col, m_sel;
  int m_err, snd_end, hands_end, jaw_end, fog_end, cool_end;

  task automatic model_clear(input bit keep_err);
    m_pw = 0; m_col = 2'b00; m_sel = 2'b00; m_busy = 0;
    snd_end = 0; hands_end = 0; jaw_end = 0; fog_end = 0; cool_end = 0;
    if (!keep_err) m_err = 0;
  endtask

  // Drive one cycle's command and queue the outputs required after the following edge.
  task automatic cycle(input logic v, input logic [15:0] c, input logic r, input string tag);
    logic [18:0] e;
    bit mal;
    @(negedge clk);
    rst = r; i_cmd_valid = v; i_cmd_onehot = c;
    k++;
    m_busy = 0;
    if (r) model_clear(0);
    else if (v) begin
      mal = ($countones(c) != 1) || ((c & 16'h888C) != 16'h0);
      if (mal) begin
        if (m_err < 255) m_err++;
      end else if (!m_pw) begin
        if (c[0]) m_pw = 1;
      end else if (c[1]) model_clear(1);
      else if (c[4]) m_col = 2'b01;
      else if (c[5]) m_col = 2'b10;
      else if (c[6]) m_col = 2'b11;
      else if (c[8] || c[9] || c[10]) begin
        if (k - 1 < snd_end) m_busy = 1;
        else begin
          snd_end = k + SL;
          m_sel = c[8] ? 2'b00 : (c[9] ? 2'b01 : 2'b10);
        end
      end else if (c[12]) hands_end = k + ML;
      else if (c[13]) jaw_end = k + ML;
      else if (c[14]) begin
        if (k - 1 < cool_end) m_busy = 1;
        else begin
          fog_end = k + FL;
          cool_end = fog_end + CL;
        end
      end
    end
    e = {m_pw, m_col, (k < snd_end), m_sel, (k < hands_end), (k < jaw_end), (k < fog_end),
         ((k >= fog_end) && (k < cool_end)), m_busy, 8'(m_err)};
    q_exp.push_back(e);
    q_tag.push_back(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0000, 1'b0, tag);
  endtask

  task automatic async_rst_check(input string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (act !== 19'd0) begin
      n_bad++;
      $display("FAIL %s: got %b required %b", tag, act, 19'd0);
    end
  endtask

  logic [18:0] mon_exp;
  string       mon_tag;
  always begin
    @(posedge clk);
    #1;
    if (q_exp.size() != 0) begin
      mon_exp = q_exp.pop_front();
      mon_tag = q_tag.pop_front();
      n_cmp++;
      if (act !== mon_exp) begin
        n_bad++;
        $display("FAIL %s: got %b required %b", mon_tag, act, mon_exp);
      end
    end
  end

  initial begin
    rst = 1'b1; i_cmd_valid = 1'b0; i_cmd_onehot = 16'h0000;
    model_clear(0);

    cycle(1'b0, 16'h0000, 1'b1, "reset");
    cycle(1'b0, 16'h0000, 1'b1, "reset");
    cycle(1'b1, 16'h0010, 1'b0, "green_unpowered");
    cycle(1'b1, 16'h0001, 1'b0, "on");
    cycle(1'b1, 16'h0020, 1'b0, "purple");
    idle(2, "colour_hold");

    cycle(1'b1, 16'h0100, 1'b0, "scream");
    idle(2, "scream_play");
    cycle(1'b1, 16'h0200, 1'b0, "cackle_busy");
    idle(5, "scream_play");
    cycle(1'b1, 16'h0200, 1'b0, "cackle_ok");
    idle(7, "cackle_play");
    cycle(1'b1, 16'h0400, 1'b0, "boo_last_cycle_busy");
    idle(3, "snd_idle");

    cycle(1'b1, 16'h4000, 1'b0, "fog");
    idle(10, "fog_run");
    cycle(1'b1, 16'h4000, 1'b0, "fog_cool5_busy");
    idle(4, "fog_cool");
    cycle(1'b1, 16'h4000, 1'b0, "fog_cool_last_busy");
    cycle(1'b1, 16'h4000, 1'b0, "fog_reaccept");
    idle(17, "fog_run2");

    cycle(1'b1, 16'h1000, 1'b0, "wave");
    cycle(1'b1, 16'h2000, 1'b0, "jaw");
    cycle(1'b1, 16'h1000, 1'b0, "wave_retrig");
    idle(6, "move_run");
    cycle(1'b0, 16'h00FF, 1'b0, "invalid_ignored");
    cycle(1'b1, 16'h0040, 1'b0, "orange");
    cycle(1'b1, 16'h0001, 1'b0, "on_again");

    cycle(1'b1, 16'h0000, 1'b0, "mal_zero");
    cycle(1'b1, 16'h0030, 1'b0, "mal_two_hot");
    cycle(1'b1, 16'h0100, 1'b0, "scream2");
    idle(2, "scream2_play");
    cycle(1'b1, 16'h0002, 1'b0, "soft_reset");
    idle(1, "soft_hold");
    cycle(1'b1, 16'h0010, 1'b0, "green_after_soft");

    cycle(1'b1, 16'h0001, 1'b0, "on_after_soft");
    cycle(1'b1, 16'h4000, 1'b0, "fog_pre_rst");
    idle(3, "fog_pre_rst");
    async_rst_check("async_rst");
    cycle(1'b0, 16'h0000, 1'b1, "rst_held");
    cycle(1'b0, 16'h0000, 1'b0, "rst_release");

    cycle(1'b1, 16'h0000, 1'b0, "err1");
    cycle(1'b1, 16'h0030, 1'b0, "err2");
    cycle(1'b1, 16'h0004, 1'b0, "err3");
    for (int i = 0; i < 260; i++) cycle(1'b1, 16'h8000, 1'b0, "err_sat");
    cycle(1'b1, 16'h0001, 1'b0, "on_err_sat");
    idle(2, "err_hold");

    @(posedge clk);
    #3;
    if (q_exp.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending required 0", q_exp.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
